// File: rtl/mapper_sdram_bridge_pkg.sv
// Shared definitions for the mapper-to-SDRAM bridge: FSM encoding,
// address width and the fixed data returned for unmapped or failed accesses.
package mapper_sdram_bridge_pkg;

    localparam int ADDR_W = 27;

    localparam logic [ADDR_W-1:0] UNMAPPED_ADDR = {ADDR_W{1'b1}};
    localparam logic [7:0]        FF_DATA       = 8'hFF;

    typedef logic [1:0] bridge_state_t;

    localparam bridge_state_t ST_IDLE     = 2'd0;
    localparam bridge_state_t ST_WAIT_ACK = 2'd1;
    localparam bridge_state_t ST_HOLD     = 2'd2;

endpackage

// File: rtl/mapper_sdram_bridge.sv
// Bridges translated cartridge-mapper accesses onto the SDRAM controller
// req/ack port, stalling the CPU until data returns or the request times out.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a qualifying CPU access
// WAIT_ACK | request outstanding at the controller, CPU stalled
// HOLD     | access finished, read data held until mreq drops
module mapper_sdram_bridge
    import mapper_sdram_bridge_pkg::*;
#(
    parameter int ADDR_W  = mapper_sdram_bridge_pkg::ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              mreq,
    input  logic              rd,
    input  logic              wr,
    input  logic [7:0]        cpu_wdata,
    input  logic              map_ram_cs,
    input  logic              map_ram_we,
    input  logic [ADDR_W-1:0] map_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_wait_n,
    output logic [7:0]        cpu_rdata,
    output logic              timeout_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    bridge_state_t    state;
    logic [CNT_W-1:0] counter;
    logic             rd_hit;
    logic             wr_hit;
    logic             any_hit;
    logic             mapped;

    // Access qualification; a simultaneous rd/wr is treated as a read.
    always_comb begin
        rd_hit     = mreq & rd & map_ram_cs;
        wr_hit     = mreq & wr & map_ram_we & ~rd;
        any_hit    = rd_hit | wr_hit;
        mapped     = (map_addr != {ADDR_W{1'b1}});
        cpu_wait_n = ~(((state == ST_IDLE) & any_hit & mapped) |
                       (state == ST_WAIT_ACK));
    end

    // Request FSM with saturating timeout counter and sticky error flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            cpu_rdata   <= FF_DATA;
            timeout_err <= 1'b0;
            counter     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_hit) begin
                        if (mapped) begin
                            mem_addr  <= map_addr;
                            mem_we    <= wr_hit;
                            mem_wdata <= cpu_wdata;
                            mem_req   <= 1'b1;
                            counter   <= '0;
                            state     <= ST_WAIT_ACK;
                        end else begin
                            cpu_rdata <= FF_DATA;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack coinciding with the last timeout cycle still wins.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            cpu_rdata <= mem_rdata;
                        end
                        state <= ST_HOLD;
                    end else if (counter == CNT_LAST) begin
                        mem_req     <= 1'b0;
                        cpu_rdata   <= FF_DATA;
                        timeout_err <= 1'b1;
                        state       <= ST_HOLD;
                    end else if (counter != CNT_MAX) begin
                        counter <= counter + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!mreq) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mapper_sdram_bridge.md
Name: mapper_sdram_bridge

Overview:
- Sits downstream of the cartridge mappers.
- Consumes the mapper output (ram_cs, 27-bit translated address) together with the CPU strobes.
- Acts as initiator toward the SDRAM controller's req/ack port.
- Stalls the CPU via wait_n until data returns, then holds read data until the CPU cycle ends. Unmapped or timed-out accesses return 8'hFF.

Parameters:
- ADDR_W, 27, width of translated memory address.
- TIMEOUT, 255, clk_sys cycles to wait for mem_ack before abandoning a request.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mreq  in  1  CPU memory request
- rd  in  1  CPU read strobe
- wr  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- map_ram_cs  in  1  mapper: address valid for read
- map_ram_we  in  1  mapper: address valid for write (SRAM/RAM mappers)
- map_addr  in  ADDR_W  mapper translated address; all-ones means unmapped
- mem_req  out  1  request to SDRAM controller
- mem_we  out  1  request is a write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  8  request write data
- mem_ack  in  1  single-cycle completion pulse from controller
- mem_rdata  in  8  read data, valid when mem_ack=1
- cpu_wait_n  out  1  low stalls CPU
- cpu_rdata  out  8  data to CPU
- timeout_err  out  1  sticky: a request timed out

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is asynchronous and active-high.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=8'hFF, timeout_err=0, counter=0, cpu_wait_n=1.
- Qualifying access (evaluated in IDLE):
  - rd_hit = mreq & rd & map_ram_cs.
  - wr_hit = mreq & wr & map_ram_we & ~rd.
  - If rd and wr are both high, the access is treated as a read.
- FSM states: IDLE, WAIT_ACK, HOLD.
- IDLE:
  - On rd_hit or wr_hit with map_addr != all-ones: capture map_addr into mem_addr, wr_hit into mem_we, cpu_wdata into mem_wdata. Set mem_req=1, counter=0, go to WAIT_ACK.
  - On a hit with map_addr all-ones: cpu_rdata=8'hFF, go to HOLD, no memory request.
  - mem_ack in IDLE is ignored.
- WAIT_ACK:
  - mem_req stays 1 and mem_addr/we/wdata stay stable. Counter increments each cycle.
  - On mem_ack=1: mem_req=0. If read, cpu_rdata=mem_rdata; if write, cpu_rdata is unchanged. Go to HOLD.
  - On counter==TIMEOUT-1 without ack: mem_req=0, cpu_rdata=8'hFF, timeout_err=1, go to HOLD.
  - An ack on the same cycle as the timeout wins: data is accepted and no error is set.
- HOLD:
  - cpu_rdata held.
  - When mreq=0: go to IDLE. A new access needs mreq to deassert first, so no double issue within one CPU cycle.
- cpu_wait_n (combinational):
  - 0 when in IDLE with a mapped hit, or in WAIT_ACK.
  - 1 otherwise, including unmapped hits and HOLD.
- Latency:
  - Hit at cycle N puts mem_req high from N+1.
  - Ack at cycle M puts cpu_rdata valid and cpu_wait_n=1 at M+1.
  - Minimum stall is 2 clk_sys cycles.
- Mapper inputs are ignored outside IDLE; mid-access changes to map_addr do not alter mem_addr.
- Asynchronous reset in any state:
  - mem_req drops immediately.
  - A late mem_ack after reset is ignored (IDLE).
- timeout_err clears only on reset.
- Counter width: clog2(TIMEOUT+1); saturates, never wraps.

Decomposition:
- Shared mapper package holds:
  - The state enum type.
  - The ADDR_W constant.
  - The UNMAPPED_ADDR constant ({ADDR_W{1'b1}}).
  - The FF_DATA constant (8'hFF).
- No sub-module is needed; one FSM plus a counter. A reusable timeout_counter sub-module is acceptable if other bridges share it.

Test Plan:
- Read, mapped:
  - Stimulus: mreq=rd=map_ram_cs=1, map_addr=27'h0_4123; controller acks 3 cycles after req with 8'hA5.
  - Required: mem_req high for 3 cycles with mem_addr=27'h4123 and mem_we=0; cpu_wait_n low until ack+1; cpu_rdata=8'hA5 held until mreq falls.
- Write:
  - Stimulus: mreq=wr=map_ram_we=1, map_addr=27'h1_0000, cpu_wdata=8'h3C; ack after 1 cycle.
  - Required: mem_we=1, mem_wdata=8'h3C; single request only; cpu_rdata unchanged.
- Unmapped read:
  - Stimulus: map_ram_cs=1, map_addr=all-ones.
  - Required: mem_req never asserts; cpu_wait_n stays 1; cpu_rdata=8'hFF.
- Timeout:
  - Stimulus: mapped read, no ack, TIMEOUT=8.
  - Required: mem_req high exactly 8 cycles then low; cpu_rdata=8'hFF; timeout_err=1 and stays 1 across later successful accesses until reset.
- Reset mid-access:
  - Stimulus: assert reset while in WAIT_ACK, then pulse mem_ack after reset releases.
  - Required: mem_req=0 asynchronously; state IDLE; cpu_rdata=8'hFF; the late ack has no effect.
- Back-to-back:
  - Stimulus: mreq held high through completion; map_addr changed in HOLD.
  - Required: no second request until mreq falls and rises again; then a new request with the new address.
